// File: rtl/bus_arb_pkg.sv
// Shared definitions for the tristate alarm bus arbiter: FSM encoding and
// the width helpers used to size owner indices and counters.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } arb_state_t;

    // Index width for n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int DEF_CH       = 4;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_TURN     = 1;
    localparam int DEF_OWNER_W  = idx_width(DEF_CH);
    localparam int DEF_HOLD_W   = cnt_width(DEF_MAX_HOLD);
    localparam int DEF_TURN_W   = cnt_width(DEF_TURN);

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: rotates the request vector so that the
// base channel sits at bit 0, takes the lowest set bit, and rotates back.
module rr_priority_picker
    import bus_arb_pkg::*;
#(
    parameter int CH = 4,
    localparam int IW = idx_width(CH)
) (
    input  logic [CH-1:0] req,
    input  logic [IW-1:0] base,
    output logic [CH-1:0] pick,
    output logic [IW-1:0] index,
    output logic          any
);

    localparam int DW = IW + 1;

    logic [2*CH-1:0] dbl;
    logic [CH-1:0]   rot;
    logic [IW-1:0]   pos;
    logic [DW-1:0]   sum;

    assign dbl = {req, req};

    // rot[gi] is the request of channel (base + gi) mod CH.
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_rot
            localparam logic [DW-1:0] OFF = DW'(gi);
            assign rot[gi] = dbl[OFF + {1'b0, base}];
        end
    endgenerate

    always_comb begin
        pos = '0;
        any = 1'b0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = IW'(i);
                any = 1'b1;
            end
        end
    end

    always_comb begin
        sum   = {1'b0, pos} + {1'b0, base};
        index = (sum >= DW'(CH)) ? IW'(sum - DW'(CH)) : IW'(sum);
        pick  = any ? (CH'(1) << index) : '0;
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter and driver for a shared tristate alarm bus, with
// hold-time limiting, a timeout pulse and a turnaround gap between owners.
module tristate_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int CH       = 4,
    parameter int MAX_HOLD = 16,
    parameter int TURN     = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CH-1:0]              req,
    input  logic [CH-1:0]              done,
    input  logic [CH*N-1:0]            data_in,
    output logic [CH-1:0]              grant,
    output logic [idx_width(CH)-1:0]   owner,
    output logic [N-1:0]               bus,
    output logic                       bus_valid,
    output logic                       timeout
);

    localparam int OW = idx_width(CH);
    localparam int HW = cnt_width(MAX_HOLD);
    localparam int TW = cnt_width(TURN);
    localparam logic [TW-1:0] TURN_LAST = TW'((TURN > 0) ? TURN - 1 : 0);

    arb_state_t      state_reg, state_next;
    logic [CH-1:0]   grant_reg, grant_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic [OW-1:0]   base_reg, base_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [TW-1:0]   turn_cnt_reg, turn_cnt_next;
    logic            timeout_reg, timeout_next;

    logic [CH-1:0]   pick;
    logic [OW-1:0]   pick_idx;
    logic            pick_any;
    logic            own_req;
    logic            own_done;
    logic            hold_limit;
    logic [N-1:0]    words [CH];

    rr_priority_picker #(.CH(CH)) u_picker (
        .req   (req),
        .base  (base_reg),
        .pick  (pick),
        .index (pick_idx),
        .any   (pick_any)
    );

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_words
            assign words[gi] = data_in[gi*N +: N];
        end
    endgenerate

    assign own_req    = req[owner_reg];
    assign own_done   = done[owner_reg];
    assign hold_limit = (hold_cnt_reg == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            owner_reg    <= '0;
            base_reg     <= '0;
            hold_cnt_reg <= '0;
            turn_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            owner_reg    <= owner_next;
            base_reg     <= base_next;
            hold_cnt_reg <= hold_cnt_next;
            turn_cnt_reg <= turn_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        owner_next    = owner_reg;
        base_next     = base_reg;
        hold_cnt_next = hold_cnt_reg;
        turn_cnt_next = turn_cnt_reg;
        timeout_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next    = GRANT;
                    grant_next    = pick;
                    owner_next    = pick_idx;
                    base_next     = (pick_idx == OW'(CH - 1)) ? '0 : pick_idx + OW'(1);
                    hold_cnt_next = '0;
                end
            end
            GRANT: begin
                if (hold_cnt_reg < HW'(MAX_HOLD))
                    hold_cnt_next = hold_cnt_reg + HW'(1);
                if (own_done || !own_req || hold_limit) begin
                    grant_next    = '0;
                    // A release that coincides with the limit is a normal release.
                    timeout_next  = hold_limit && own_req && !own_done;
                    turn_cnt_next = '0;
                    state_next    = (TURN > 0) ? TURNAROUND : IDLE;
                end
            end
            TURNAROUND: begin
                if (turn_cnt_reg >= TURN_LAST)
                    state_next = IDLE;
                else
                    turn_cnt_next = turn_cnt_reg + TW'(1);
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    assign grant     = grant_reg;
    assign owner     = owner_reg;
    assign timeout   = timeout_reg;
    assign bus_valid = |grant_reg;
    assign bus       = bus_valid ? words[owner_reg] : {N{1'bz}};

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (N=8, CH=4, MAX_HOLD=16, TURN=1).
module tb_tristate_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [31:0] data_in;
    logic [3:0]  grant;
    logic [1:0]  owner;
    wire  [7:0]  bus;
    logic        bus_valid;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    tristate_bus_arbiter #(.N(8), .CH(4), .MAX_HOLD(16), .TURN(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .data_in   (data_in),
        .grant     (grant),
        .owner     (owner),
        .bus       (bus),
        .bus_valid (bus_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input string tag, input int k);
        check({tag, ".grant"}, 32'(grant), 32'(1) << k);
        check({tag, ".owner"}, 32'(owner), 32'(k));
        check({tag, ".valid"}, 32'(bus_valid), 32'd1);
        check({tag, ".bus"}, 32'(bus), 32'(data_in[k*8 +: 8]));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".grant"}, 32'(grant), 32'd0);
        check({tag, ".valid"}, 32'(bus_valid), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        req     = 4'b1111;
        done    = 4'b0000;
        data_in = {8'h44, 8'hA5, 8'h22, 8'h11};

        // Reset held with all channels requesting.
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_idle($sformatf("rst%0d", i));
            check($sformatf("rst%0d.timeout", i), 32'(timeout), 32'd0);
            check($sformatf("rst%0d.owner", i), 32'(owner), 32'd0);
        end
        reset = 1'b0;
        req   = 4'b0000;
        tick();
        expect_idle("idle0");

        // Single request on channel 2, released by done in its third cycle.
        req = 4'b0100;
        tick();
        expect_grant("single.g1", 2);
        tick();
        expect_grant("single.g2", 2);
        tick();
        expect_grant("single.g3", 2);
        done = 4'b0100;
        tick();
        expect_idle("single.turn");
        check("single.turn.owner", 32'(owner), 32'd2);
        check("single.turn.timeout", 32'(timeout), 32'd0);
        done = 4'b0000;
        req  = 4'b0000;
        tick();
        expect_idle("single.idle");

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2.owner", 32'(owner), 32'd0);

        // Round-robin with all channels requesting, done in each second cycle.
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int k;
            k = n % 4;
            tick();
            expect_grant($sformatf("rr%0d.g1", n), k);
            tick();
            expect_grant($sformatf("rr%0d.g2", n), k);
            done = 4'(1 << k);
            tick();
            expect_idle($sformatf("rr%0d.turn", n));
            done = 4'b0000;
            if (n == 4) req = 4'b0000;
            tick();
            expect_idle($sformatf("rr%0d.idle", n));
        end

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Hold limit: channel 0 is cut off after 16 cycles, channel 1 follows.
        req = 4'b0011;
        tick();
        for (int i = 0; i < 16; i++) begin
            expect_grant($sformatf("hold%0d", i), 0);
            check($sformatf("hold%0d.timeout", i), 32'(timeout), 32'd0);
            if (i == 7) data_in[7:0] = 8'h5A;
            if (i < 15) tick();
        end
        tick();
        expect_idle("to.turn");
        check("to.turn.timeout", 32'(timeout), 32'd1);
        tick();
        expect_idle("to.idle");
        check("to.idle.timeout", 32'(timeout), 32'd0);
        tick();
        expect_grant("to.next", 1);
        req = 4'b0000;
        tick();
        expect_idle("to.rel");
        check("to.rel.timeout", 32'(timeout), 32'd0);
        data_in[7:0] = 8'h11;
        tick();

        // done in the same cycle as the hold limit: plain release.
        req = 4'b0011;
        tick();
        expect_grant("lim.g1", 0);
        for (int i = 1; i < 16; i++) tick();
        expect_grant("lim.g16", 0);
        done = 4'b0001;
        tick();
        expect_idle("lim.turn");
        check("lim.turn.timeout", 32'(timeout), 32'd0);
        done = 4'b0000;
        req  = 4'b0000;
        tick();
        expect_idle("lim.idle");

        // Reset during the fifth grant cycle; a non-owner done is ignored first.
        req = 4'b0110;
        tick();
        expect_grant("mid.g1", 1);
        tick();
        done = 4'b0100;
        tick();
        expect_grant("mid.g3", 1);
        done = 4'b0000;
        tick();
        tick();
        expect_grant("mid.g5", 1);
        reset = 1'b1;
        tick();
        expect_idle("mid.rst");
        check("mid.rst.owner", 32'(owner), 32'd0);
        check("mid.rst.timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        tick();
        expect_grant("mid.regrant", 1);
        req = 4'b0000;
        tick();
        tick();
        expect_idle("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
